// File: rtl/control_unit.sv
// Mini SRC hardwired control sequencer: fetch T0-T2, opcode-driven execute T3-T7, one control word per clock.
// Outputs decode state_q and ir[31:27] combinationally; define CONTROL_BRANCH_EN to execute br (10010) instead of treating it as nop.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        PCout,
  output logic        IncPC,
  output logic        ZLOout,
  output logic        ZLOin,
  output logic        Cout,
  output logic        MDRout,
  output logic        RAMenable,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        read,
  output logic        write,
  output logic        conin,
  output logic        ZMuxEnable,
  output logic        ZSelect,
  output logic        ZMuxOut,
  output logic [4:0]  aluControl,
  output logic        run,
  output logic [3:0]  step
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd15
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_q, state_d;
  logic [4:0] opcode;
  logic       is_alu_r, is_alu_i, is_ldx, is_br, z_rd;
  logic [4:0] imm_alu;
  logic       unused_in;

  assign opcode    = ir[31:27];
  assign unused_in = ^{ir[26:0], con_ff};

  assign is_alu_r = (opcode == 5'b00011) || (opcode == 5'b00100) ||
                    (opcode == 5'b00101) || (opcode == 5'b00110);
  assign is_alu_i = (opcode == 5'b01100) || (opcode == 5'b01101) || (opcode == 5'b01110);
  assign is_ldx   = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
`ifdef CONTROL_BRANCH_EN
  assign is_br    = (opcode == 5'b10010);
`else
  assign is_br    = 1'b0;
`endif

  always_comb begin
    imm_alu = OP_ADD;
    case (opcode)
      5'b01101: imm_alu = OP_AND;
      5'b01110: imm_alu = OP_OR;
      default:  imm_alu = OP_ADD;
    endcase
  end

  // "Z read" drives three strobes together; ZSelect is always low.
  assign ZLOout     = z_rd;
  assign ZMuxEnable = z_rd;
  assign ZMuxOut    = z_rd;
  assign ZSelect    = 1'b0;
  assign step       = state_q;
  assign run        = (state_q != S_IDLE) && (state_q != S_HALT);

  always_comb begin
    state_d = state_q;
    z_rd = 1'b0; PCout = 1'b0; IncPC = 1'b0; ZLOin = 1'b0; Cout = 1'b0;
    MDRout = 1'b0; RAMenable = 1'b0; MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0;
    Rout = 1'b0; BAout = 1'b0; read = 1'b0; write = 1'b0; conin = 1'b0;
    aluControl = 5'b00000;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        z_rd = 1'b1; PCin = 1'b1; read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T0;
        if (is_alu_r || is_alu_i) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = S_T4;
        end else if (is_ldx) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_d = S_T4;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; conin = 1'b1; state_d = S_T4;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end
      end
      S_T4: begin
        state_d = S_T5;
        if (is_alu_r) begin
          Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; aluControl = opcode;
        end else if (is_alu_i) begin
          Cout = 1'b1; ZLOin = 1'b1; aluControl = imm_alu;
        end else if (is_ldx) begin
          Cout = 1'b1; ZLOin = 1'b1; aluControl = OP_ADD;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end else begin
          state_d = S_T0;
        end
      end
      S_T5: begin
        state_d = S_T0;
        if (opcode == OP_LD || opcode == OP_ST) begin
          z_rd = 1'b1; MARin = 1'b1; state_d = S_T6;
        end else if (is_br) begin
          Cout = 1'b1; ZLOin = 1'b1; aluControl = OP_ADD; state_d = S_T6;
        end else if (is_alu_r || is_alu_i || is_ldx) begin
          z_rd = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        state_d = S_T0;
        if (opcode == OP_LD) begin
          read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; state_d = S_T7;
        end else if (opcode == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = S_T7;
        end else if (is_br && con_ff) begin
          z_rd = 1'b1; PCin = 1'b1;
        end
      end
      S_T7: begin
        state_d = S_T0;
        if (opcode == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (opcode == OP_ST) begin
          write = 1'b1; RAMenable = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a step-by-step expected control word queue is filled per instruction
// and drained one entry per clock, compared against the DUT outputs 1ns after each rising edge.
module tb_control_unit;
  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir = 32'h2800_0000;
  logic        con_ff = 1'b0;
  logic PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin, PCin, MDRin, IRin, Yin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, read, write, conin, ZMuxEnable, ZSelect, ZMuxOut;
  logic [4:0] aluControl;
  logic       run;
  logic [3:0] step;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
    .PCout(PCout), .IncPC(IncPC), .ZLOout(ZLOout), .ZLOin(ZLOin), .Cout(Cout),
    .MDRout(MDRout), .RAMenable(RAMenable), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .read(read), .write(write), .conin(conin), .ZMuxEnable(ZMuxEnable),
    .ZSelect(ZSelect), .ZMuxOut(ZMuxOut), .aluControl(aluControl), .run(run), .step(step)
  );

  always #5 clock = ~clock;

  localparam logic [23:0] PCOUT = 24'h800000, INCPC = 24'h400000, ZLOOUT = 24'h200000, ZLOIN = 24'h100000;
  localparam logic [23:0] COUT = 24'h080000, MDROUT = 24'h040000, RAMEN = 24'h020000, MARIN = 24'h010000;
  localparam logic [23:0] PCIN = 24'h008000, MDRIN = 24'h004000, IRIN = 24'h002000, YIN = 24'h001000;
  localparam logic [23:0] GRA = 24'h000800, GRB = 24'h000400, GRC = 24'h000200, RIN = 24'h000100;
  localparam logic [23:0] ROUT = 24'h000080, BAOUT = 24'h000040, READ = 24'h000020, WRITE = 24'h000010;
  localparam logic [23:0] CONIN = 24'h000008, ZMUXEN = 24'h000004, ZSEL = 24'h000002, ZMUXOUT = 24'h000001;
  localparam logic [23:0] ZRD = ZLOOUT | ZMUXEN | ZMUXOUT;

  typedef struct packed {
    logic [3:0]  st;
    logic        rn;
    logic [4:0]  alu;
    logic [23:0] strb;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  logic [23:0] obs_strb;
  exp_t        obs;
  assign obs_strb = {PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin, PCin, MDRin, IRin, Yin,
                     Gra, Grb, Grc, Rin, Rout, BAout, read, write, conin, ZMuxEnable, ZSelect, ZMuxOut};
  assign obs = {step, run, aluControl, obs_strb};

  task automatic push(input string tag, input logic [3:0] st, input logic [23:0] s, input logic [4:0] a);
    exp_t e;
    e.st   = st;
    e.rn   = (st != 4'd0) && (st != 4'd15);
    e.alu  = a;
    e.strb = s;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_next();
    exp_t  e;
    string t;
    @(posedge clock);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h required=an expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed step=%0d run=%b alu=%b strb=%h required step=%0d run=%b alu=%b strb=%h",
               t, obs.st, obs.rn, obs.alu, obs.strb, e.st, e.rn, e.alu, e.strb);
      end
    end
  endtask

  task automatic push_instr(input string nm, input logic [4:0] op, input logic cff);
    logic [4:0] ialu;
    push({nm, "/T0"}, 4'd1, PCOUT | MARIN | INCPC | ZLOIN, 5'd0);
    push({nm, "/T1"}, 4'd2, ZRD | PCIN | READ | RAMEN | MDRIN, 5'd0);
    push({nm, "/T2"}, 4'd3, MDROUT | IRIN, 5'd0);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push({nm, "/T3"}, 4'd4, GRB | ROUT | YIN, 5'd0);
        push({nm, "/T4"}, 4'd5, GRC | ROUT | ZLOIN, op);
        push({nm, "/T5"}, 4'd6, ZRD | GRA | RIN, 5'd0);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        ialu = (op == 5'b01100) ? 5'b00011 : (op == 5'b01101) ? 5'b00101 : 5'b00110;
        push({nm, "/T3"}, 4'd4, GRB | ROUT | YIN, 5'd0);
        push({nm, "/T4"}, 4'd5, COUT | ZLOIN, ialu);
        push({nm, "/T5"}, 4'd6, ZRD | GRA | RIN, 5'd0);
      end
      5'b00001, 5'b00000, 5'b00010: begin
        push({nm, "/T3"}, 4'd4, GRB | BAOUT | YIN, 5'd0);
        push({nm, "/T4"}, 4'd5, COUT | ZLOIN, 5'b00011);
        if (op == 5'b00001) begin
          push({nm, "/T5"}, 4'd6, ZRD | GRA | RIN, 5'd0);
        end else begin
          push({nm, "/T5"}, 4'd6, ZRD | MARIN, 5'd0);
          if (op == 5'b00000) begin
            push({nm, "/T6"}, 4'd7, READ | RAMEN | MDRIN, 5'd0);
            push({nm, "/T7"}, 4'd8, MDROUT | GRA | RIN, 5'd0);
          end else begin
            push({nm, "/T6"}, 4'd7, GRA | ROUT | MDRIN, 5'd0);
            push({nm, "/T7"}, 4'd8, WRITE | RAMEN, 5'd0);
          end
        end
      end
`ifdef CONTROL_BRANCH_EN
      5'b10010: begin
        push({nm, "/T3"}, 4'd4, GRA | ROUT | CONIN, 5'd0);
        push({nm, "/T4"}, 4'd5, PCOUT | YIN, 5'd0);
        push({nm, "/T5"}, 4'd6, COUT | ZLOIN, 5'b00011);
        push({nm, "/T6"}, 4'd7, cff ? (ZRD | PCIN) : 24'd0, 5'd0);
      end
`endif
      5'b11011: begin
        push({nm, "/T3"}, 4'd4, 24'd0, 5'd0);
        for (int i = 0; i < 20; i++) push({nm, "/HALT"}, 4'd15, 24'd0, 5'd0);
      end
      default: push({nm, "/T3"}, 4'd4, 24'd0, 5'd0);
    endcase
  endtask

  // IR and con_ff change only after the T0 check, so the previous instruction's last step is never disturbed.
  task automatic run_instr(input string nm, input logic [4:0] op, input logic cff, input int limit);
    int n;
    push_instr(nm, op, cff);
    n = (limit > 0) ? limit : sb_q.size();
    for (int k = 0; k < n; k++) begin
      check_next();
      if (k == 0) begin
        ir = {op, 27'($urandom)};
        con_ff = cff;
      end
    end
    sb_q.delete();
    tag_q.delete();
  endtask

  initial begin
    push("reset0", 4'd0, 24'd0, 5'd0);
    push("reset1_idle", 4'd0, 24'd0, 5'd0);
    check_next();
    check_next();
    clear = 1'b0;

    run_instr("and",  5'b00101, 1'b0, 0);
    run_instr("andi", 5'b01101, 1'b0, 0);
    run_instr("add",  5'b00011, 1'b0, 0);
    run_instr("sub",  5'b00100, 1'b0, 0);
    run_instr("or",   5'b00110, 1'b0, 0);
    run_instr("addi", 5'b01100, 1'b0, 0);
    run_instr("ori",  5'b01110, 1'b0, 0);
    run_instr("ldi",  5'b00001, 1'b0, 0);
    run_instr("ld",   5'b00000, 1'b0, 0);
    run_instr("st",   5'b00010, 1'b0, 0);
    run_instr("nop",  5'b11010, 1'b0, 0);
    run_instr("undef", 5'b11111, 1'b1, 0);
    run_instr("br_t", 5'b10010, 1'b1, 0);
    run_instr("br_f", 5'b10010, 1'b0, 0);
    run_instr("halt", 5'b11011, 1'b0, 0);

    clear = 1'b1;
    push("clear_from_halt", 4'd0, 24'd0, 5'd0);
    check_next();
    clear = 1'b0;

    run_instr("ld_abort", 5'b00000, 1'b0, 7);
    clear = 1'b1;
    push("clear_mid_ld", 4'd0, 24'd0, 5'd0);
    check_next();
    clear = 1'b0;

    run_instr("st_after_abort", 5'b00010, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the Mini SRC CPU; it is the block that drives the datapath control inputs that benches have driven by hand until now. It steps through fetch (T0–T2) and per-opcode execute steps (T3–T7), decoding IR[31:27] from the datapath's IR register. It emits one control word per clock until it halts or is cleared.

## Interface
Parameters:
- none

Ports:
- clock  in  1  system clock; all state updates on rising edge
- clear  in  1  synchronous, active-high reset
- ir  in  32  datapath IR contents; only ir[31:27] (opcode) is used
- con_ff  in  1  CON FF result from datapath
- PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin, PCin, MDRin, IRin, Yin  out  1 each  datapath/memory strobes
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select strobes
- read, write, conin  out  1 each  memory read/write, CON FF load
- ZMuxEnable, ZSelect, ZMuxOut  out  1 each  Z-to-bus mux controls
- aluControl  out  5  ALU operation code
- run  out  1  high except in IDLE and HALT
- step  out  4  current state: IDLE=0, T0..T7=1..8, HALT=15

## Operation
- Each state lasts one clock. Outputs are a combinational decode of the state register and ir[31:27]. The IR is stable from T3 onward.
- "Z read" means ZLOout=1, ZMuxEnable=1, ZMuxOut=1, ZSelect=0, all asserted together.
- Every signal not listed for a step is 0. aluControl=0 unless listed.
- IDLE: all outputs 0. Next state is T0.
- Fetch:
  - T0: PCout, MARin, IncPC, ZLOin.
  - T1: Z read, PCin, read, RAMenable, MDRin.
  - T2: MDRout, IRin.
- ALU register ops (add 00011, sub 00100, and 00101, or 00110):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ZLOin, aluControl=opcode.
  - T5: Z read, Gra, Rin. Next state is T0.
- ALU immediate ops (addi 01100→00011, andi 01101→00101, ori 01110→00110):
  - T3: Grb, Rout, Yin.
  - T4: Cout, ZLOin, aluControl=mapped code.
  - T5: Z read, Gra, Rin. Next state is T0.
- ldi 00001:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ZLOin, aluControl=00011.
  - T5: Z read, Gra, Rin. Next state is T0.
- ld 00000:
  - T3–T4: same as ldi.
  - T5: Z read, MARin.
  - T6: read, RAMenable, MDRin.
  - T7: MDRout, Gra, Rin. Next state is T0.
- st 00010:
  - T3–T5: same as ld.
  - T6: Gra, Rout, MDRin.
  - T7: write, RAMenable. Next state is T0.
- nop 11010: T3 outputs all 0, then T0.
- halt 11011: T3 outputs all 0, then HALT. HALT holds all outputs 0 until clear.
- Any undefined opcode behaves as nop.

## Timing
- clear high at a rising edge puts the block in IDLE on that edge, regardless of state. This includes mid-instruction; partial writes are not completed.
- After clear deasserts: IDLE (1 cycle), then T0.
- Reset value of every output is 0, with step=0 and run=0.
- Instruction lengths, including fetch: ALU/imm/ldi 6 cycles; ld/st 8; nop 4; branch 7.
- Consecutive instructions are back-to-back: the last execute step is followed directly by T0, with no bubble.
- write and read are never asserted in the same cycle.
- RAMenable is asserted only together with read or write.

## Configuration
- CONTROL_BRANCH_EN defined: opcode 10010 (br) is executed as follows.
  - T3: Gra, Rout, conin.
  - T4: PCout, Yin.
  - T5: Grb, BAout... no: Cout, ZLOin, aluControl=00011.
  - T6: if con_ff=1, Z read and PCin; otherwise all outputs 0.
  - Next state is T0.
- CONTROL_BRANCH_EN undefined: 10010 decodes as nop (4 cycles). con_ff is ignored.

## Test plan
- clear held 2 cycles, then released → step=0 for one cycle, then 1; all outputs 0 during clear.
- ir[31:27]=00101 (and) → T3 Grb/Rout/Yin; T4 Grc/Rout/ZLOin with aluControl=00101; T5 Z read/Gra/Rin; step returns to 1 on cycle 7.
- ir[31:27]=01101 (andi) → T4 Cout=1 with aluControl=00101; st (00010) → T7 write=1, RAMenable=1, read=0; ld takes 8 cycles.
- ir[31:27]=11011 (halt) → step=15, run=0, outputs frozen at 0 for 20 cycles; clear → IDLE.
- clear asserted during T6 of ld → next step=0 and read=0; the instruction is abandoned.
- With CONTROL_BRANCH_EN: br, con_ff=1 → T6 PCin=1; con_ff=0 → T6 PCin=0. Without the macro: br completes in 4 cycles.
